// File: rtl/emmc_ddr_rx_packer.sv
// rtl/emmc_ddr_rx_packer.sv - eMMC DDR 8-lane receive packer
// Finds block start bits, packs payload byte pairs into 32-bit FIFO words, checks end bits.
module emmc_ddr_rx_packer #(
  parameter int BLOCK_BYTES    = 512,
  parameter int CRC_CYCLES     = 16,
  parameter int TIMEOUT_CYCLES = 65535
) (
  input  logic        i_clock,
  input  logic        i_reset,
  input  logic        i_start,
  input  logic        i_abort,
  input  logic [15:0] i_blk_cnt,
  input  logic [7:0]  i_iddr_q1,
  input  logic [7:0]  i_iddr_q2,
  input  logic        i_fifo_full,
  output logic [31:0] o_fifo_data_out,
  output logic        o_fifo_wr_en,
  output logic        o_busy,
  output logic        o_done,
  output logic        o_timeout_err,
  output logic        o_end_bit_err,
  output logic        o_overflow_err
);

  localparam int PAIRS = BLOCK_BYTES / 2;
  localparam int PW = (PAIRS > 1) ? $clog2(PAIRS) : 1;
  localparam int CW = (CRC_CYCLES > 1) ? $clog2(CRC_CYCLES) : 1;
  localparam int TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [PW-1:0] PAIR_LAST = PW'(PAIRS - 1);
  localparam logic [CW-1:0] CRC_LAST  = CW'(CRC_CYCLES - 1);
  localparam logic [TW-1:0] TMO_LAST  = TW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_WAIT_START,
    S_DATA,
    S_CRC,
    S_ENDBIT
  } state_t;

  state_t        r_state;
  state_t        w_next;
  logic [15:0]   r_blocks_left;
  logic [TW-1:0] r_tmo_cnt;
  logic [PW-1:0] r_pair_cnt;
  logic [CW-1:0] r_crc_cnt;
  logic          r_phase;
  logic [15:0]   r_word_hi;
  logic [31:0]   r_wr_data;
  logic          r_wr_pend;
  logic          r_done;
  logic          r_timeout_err;
  logic          r_end_bit_err;
  logic          r_overflow_err;
  logic          w_start_bit;
  logic          w_end_ok;

  assign w_start_bit = (i_iddr_q1 == 8'h00) && (i_iddr_q2 == 8'h00);
  assign w_end_ok    = (i_iddr_q1 == 8'hFF) && (i_iddr_q2 == 8'hFF);

  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) r_state <= S_IDLE;
    else         r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:       if (i_start && (i_blk_cnt != 16'd0)) w_next = S_WAIT_START;
      S_WAIT_START: begin
        if (w_start_bit)                  w_next = S_DATA;
        else if (r_tmo_cnt == TMO_LAST)   w_next = S_IDLE;
      end
      S_DATA:       if (r_pair_cnt == PAIR_LAST) w_next = S_CRC;
      S_CRC:        if (r_crc_cnt == CRC_LAST)   w_next = S_ENDBIT;
      S_ENDBIT:     w_next = (r_blocks_left == 16'd1) ? S_IDLE : S_WAIT_START;
      default:      w_next = S_IDLE;
    endcase
    if (i_abort) w_next = S_IDLE;
  end

  // The write strobe trails the packed word by one cycle; fifo_full is judged in that cycle.
  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      r_blocks_left  <= '0;
      r_tmo_cnt      <= '0;
      r_pair_cnt     <= '0;
      r_crc_cnt      <= '0;
      r_phase        <= 1'b0;
      r_word_hi      <= '0;
      r_wr_data      <= '0;
      r_wr_pend      <= 1'b0;
      r_done         <= 1'b0;
      r_timeout_err  <= 1'b0;
      r_end_bit_err  <= 1'b0;
      r_overflow_err <= 1'b0;
    end else begin
      r_done     <= 1'b0;
      r_wr_pend  <= 1'b0;
      r_tmo_cnt  <= (r_state == S_WAIT_START) ? r_tmo_cnt + TW'(1) : '0;
      r_pair_cnt <= (r_state == S_DATA) ? r_pair_cnt + PW'(1) : '0;
      r_crc_cnt  <= (r_state == S_CRC) ? r_crc_cnt + CW'(1) : '0;
      r_phase    <= (r_state == S_DATA) ? ~r_phase : 1'b0;
      if (r_wr_pend && i_fifo_full) r_overflow_err <= 1'b1;
      case (r_state)
        S_IDLE: begin
          if (i_start) begin
            r_timeout_err  <= 1'b0;
            r_end_bit_err  <= 1'b0;
            r_overflow_err <= 1'b0;
            if (i_blk_cnt == 16'd0) r_done <= 1'b1;
            else                    r_blocks_left <= i_blk_cnt;
          end
        end
        S_WAIT_START: begin
          if (!i_abort && !w_start_bit && (r_tmo_cnt == TMO_LAST)) r_timeout_err <= 1'b1;
        end
        S_DATA: begin
          if (!i_abort) begin
            if (r_phase) begin
              r_wr_pend <= 1'b1;
              r_wr_data <= {r_word_hi, i_iddr_q1, i_iddr_q2};
            end else begin
              r_word_hi <= {i_iddr_q1, i_iddr_q2};
            end
          end
        end
        S_ENDBIT: begin
          if (!i_abort) begin
            if (!w_end_ok) r_end_bit_err <= 1'b1;
            r_blocks_left <= r_blocks_left - 16'd1;
            if (r_blocks_left == 16'd1) r_done <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign o_fifo_data_out = r_wr_data;
  assign o_fifo_wr_en    = r_wr_pend && !i_fifo_full;
  assign o_busy          = (r_state != S_IDLE);
  assign o_done          = r_done;
  assign o_timeout_err   = r_timeout_err;
  assign o_end_bit_err   = r_end_bit_err;
  assign o_overflow_err  = r_overflow_err;

endmodule

// File: doc/emmc_ddr_rx_packer.md
Name: emmc_ddr_rx_packer

Overview:
- Downstream consumer of the 8-lane eMMC DDR input capture stage.
- Takes the per-clock rising-edge byte (Q1) and falling-edge byte (Q2) and finds the start bit of each data block.
- Packs the block payload into 32-bit words and writes them to the read-data FIFO.
- Skips the per-lane CRC field, checks the end bit, counts blocks and reports completion or errors to the data-path controller.

Parameters:
- BLOCK_BYTES, 512, payload bytes per block; multiple of 4, range 4..4096.
- CRC_CYCLES, 16, clocks occupied by the DDR CRC field after the payload.
- TIMEOUT_CYCLES, 65535, clocks allowed in WAIT_START before timeout; minimum 1.

Ports:
- clock  in  1  capture clock, the same clock driving the DDR input stage.
- reset  in  1  asynchronous, active-high reset.
- start  in  1  one-cycle pulse; arms reception. Ignored unless in IDLE.
- abort  in  1  synchronous abort; returns the block to IDLE.
- blk_cnt  in  16  number of blocks to receive; sampled on start.
- iddr_Q1  in  8  byte captured on the rising edge, lanes [7:0].
- iddr_Q2  in  8  byte captured on the falling edge, lanes [7:0].
- fifo_full  in  1  FIFO full flag.
- fifo_data_out  out  32  packed word.
- fifo_wr_en  out  1  one-cycle write strobe.
- busy  out  1  high in any state except IDLE.
- done  out  1  one-cycle pulse when all blocks complete without timeout.
- timeout_err  out  1  sticky; cleared on start.
- end_bit_err  out  1  sticky; cleared on start.
- overflow_err  out  1  sticky; cleared on start.

Behaviour:
- Reset values: all outputs 0, state IDLE, all counters 0.
- States: IDLE, WAIT_START, DATA, CRC, ENDBIT.
- IDLE:
  - start with blk_cnt != 0: load blocks_left = blk_cnt, clear the three error flags, go to WAIT_START.
  - start with blk_cnt == 0: clear the error flags, pulse done the next cycle, stay in IDLE.
- WAIT_START:
  - The start bit is held a full clock, so it is detected when iddr_Q1 == 8'h00 and iddr_Q2 == 8'h00 in the same cycle.
  - On detection: go to DATA, clear pair_cnt and the half-word phase.
  - Timeout counter loads 0 on entry and increments each cycle. When it reaches TIMEOUT_CYCLES-1 with no start bit: set timeout_err, go to IDLE, no done pulse.
- DATA, one byte pair per cycle:
  - Phase 0: word[31:24] = Q1, word[23:16] = Q2.
  - Phase 1: word[15:8] = Q1, word[7:0] = Q2.
  - The cycle after phase 1: fifo_wr_en = 1 with fifo_data_out = the completed word. Write latency is 1 clock after the fourth byte is sampled.
  - The first byte on the bus lands in bits [31:24].
  - pair_cnt counts 0..BLOCK_BYTES/2-1. At the last pair, go to CRC. The final word's strobe is issued in the first CRC cycle.
  - fifo_full sampled high in the cycle a write would occur: suppress fifo_wr_en, drop the word, set overflow_err. Reception continues with no stall; the stage has no backpressure.
- CRC:
  - Ignores the bus for exactly CRC_CYCLES clocks, then goes to ENDBIT.
- ENDBIT:
  - Requires Q1 == 8'hFF and Q2 == 8'hFF; otherwise set end_bit_err.
  - Decrement blocks_left in either case.
  - If the result is 0: go to IDLE and pulse done in the same transition cycle, registered.
  - Otherwise go to WAIT_START with the timeout counter reloaded.
- done asserts even when end_bit_err or overflow_err is set; the controller inspects the flags.
- abort:
  - Takes priority over all transitions; next state is IDLE.
  - A partially packed word is discarded. A pending write strobe scheduled for that cycle is still issued.
  - No done pulse; error flags are held.
- start while busy is ignored.
- reset mid-operation returns everything to reset values immediately, with no FIFO write.

Test Plan:
- BLOCK_BYTES=8, blk_cnt=1. Start bit, then pairs (01,02) (03,04) (05,06) (07,08), 16 CRC cycles, FF/FF. Expected: fifo writes 32'h01020304 then 32'h05060708, done pulses once, all flags 0.
- blk_cnt=2 with a 5-cycle idle gap (FF/FF) between blocks. Expected: 4 writes in order, a single done after the second end bit.
- No start bit with TIMEOUT_CYCLES=10. Expected: timeout_err=1 and busy=0 after 10 cycles in WAIT_START, no done, no writes.
- End bit sampled as Q1=FF, Q2=7F. Expected: end_bit_err=1, done still pulses, the data words are still written.
- fifo_full held high during the second word's write cycle. Expected: only the first word is written, overflow_err=1, done pulses.
- abort asserted mid-DATA after 3 pairs. Expected: exactly one write (the first word), then IDLE next cycle, no done. Then reset asserted during WAIT_START: all outputs 0 asynchronously.
